// File: rtl/hazard_pipe_ctrl.sv
// Control path for the 5-stage MIPS core: carries decoder control through the
// ID/EX, EX/MEM and MEM/WB registers, handles load-use stalls, branch/jump flushes and EX forwarding.
module hazard_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_jump,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic             id_regdst,
  input  logic [1:0]       id_aluop,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             ex_alu_zero,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pc_src_branch,
  output logic             pc_src_jump,
  output logic             ex_alusrc,
  output logic             ex_regdst,
  output logic             ex_branch,
  output logic [1:0]       ex_aluop,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [4:0]       wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // ID/EX state not exposed as outputs
  logic       ex_memread, ex_memtoreg, ex_memwrite, ex_regwrite;
  logic [4:0] ex_rd, ex_dst;
  // EX/MEM state not exposed as outputs
  logic       mem_memtoreg, mem_regwrite;
  logic [4:0] mem_dst;

  logic       stall_raw, taken, stall_eff, jump_eff, bubble;
  logic [1:0] aluop_in;

  // An unknown ALUOp from the decoder falls into the default arm and becomes 00.
  always_comb begin
    aluop_in = 2'b00;
    case (id_aluop)
      2'b01, 2'b10, 2'b11: aluop_in = id_aluop;
      default: ;
    endcase
  end

  assign ex_dst    = ex_regdst ? ex_rd : ex_rt;
  assign stall_raw = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign taken     = ex_branch & ex_alu_zero;
  assign stall_eff = stall_raw & ~taken;
  assign jump_eff  = id_jump & ~stall_raw & ~taken & ~reset;
  assign bubble    = taken | stall_raw;

  assign pc_write      = ~stall_eff;
  assign ifid_write    = ~stall_eff;
  assign ifid_flush    = taken | jump_eff;
  assign pc_src_branch = taken;
  assign pc_src_jump   = jump_eff;

  always_comb begin
    fwd_a = 2'b00;
    if (mem_regwrite && mem_dst != 5'd0 && mem_dst == ex_rs)      fwd_a = 2'b10;
    else if (wb_regwrite && wb_dst != 5'd0 && wb_dst == ex_rs)    fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_regwrite && mem_dst != 5'd0 && mem_dst == ex_rt)      fwd_b = 2'b10;
    else if (wb_regwrite && wb_dst != 5'd0 && wb_dst == ex_rt)    fwd_b = 2'b01;
  end

  // ID/EX: a bubble clears register fields too, so a bubble can never look like a hazard source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
    end else if (bubble) begin
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
    end else begin
      ex_branch   <= id_branch;
      ex_memread  <= id_memread;
      ex_memtoreg <= id_memtoreg;
      ex_memwrite <= id_memwrite;
      ex_alusrc   <= id_alusrc;
      ex_regwrite <= id_regwrite;
      ex_regdst   <= id_regdst;
      ex_aluop    <= aluop_in;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
    end
  end

  // EX/MEM and MEM/WB never stall; jump and branch bits are consumed in ID/EX and not carried further.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_dst      <= 5'd0;
      wb_memtoreg  <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_dst       <= 5'd0;
    end else begin
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_regwrite <= ex_regwrite;
      mem_dst      <= ex_dst;
      wb_memtoreg  <= mem_memtoreg;
      wb_regwrite  <= mem_regwrite;
      wb_dst       <= mem_dst;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_eff && stall_count != '1)  stall_count <= stall_count + 1'b1;
      if (ifid_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

endmodule
